pll_lock_rst_seq: RTL and testbench

//  Closes the loop around a PLL primitive: drives PLL RESET, watches the async LOCK output and

---
 rtl/pll_lock_rst_seq_pkg.sv | 28 ++
 rtl/pll_lock_rst_seq_cdc_sync_bit.sv | 27 ++
 rtl/pll_lock_rst_seq.sv | 157 +++++++++++++++
 tb/tb_pll_lock_rst_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_rst_seq_pkg.sv
// Shared definitions for the PLL lock / staged reset sequencer.
//   state_e       : FSM state encoding, also exported on state_o for debug
//   Def*          : default timing constants (cycles of the 50 MHz board clock)
//   max_u         : helper used to size the shared timer
package pll_lock_rst_seq_pkg;

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRelSys   = 3'd3,
    StRun      = 3'd4,
    StFail     = 3'd5
  } state_e;

  localparam int unsigned DefPllRstCycles     = 16;
  localparam int unsigned DefLockTimeoutCycles = 500000;  // 10 ms @ 50 MHz
  localparam int unsigned DefLockStableCycles = 1024;
  localparam int unsigned DefRstStaggerCycles = 16;
  localparam int unsigned DefMaxRetries       = 7;
  localparam int unsigned DefSyncStages       = 2;
  localparam int unsigned DefCntW             = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_rst_seq_cdc_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset to 0.
//   clk   : destination clock
//   rst_n : async active-low reset
//   d_i   : asynchronous input bit
//   q_o   : synchronized output, Stages cycles of latency
module cdc_sync_bit #(
  parameter int unsigned Stages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/pll_lock_rst_seq.sv
// PLL lock supervisor and staged reset sequencer, clocked by the free-running board clock.
// Pulses the PLL reset, waits for a stable synchronized LOCK, then releases the core reset
// and, after a stagger, the peripheral reset. Lock loss re-runs the sequence and is counted;
// repeated lock timeouts park the block in a fail state until rst_n or soft_rst_i.
//   clk, rst_n      : board clock, async active-low reset
//   pll_lock_i      : PLL LOCK (asynchronous)
//   soft_rst_i      : 1-cycle pulse, restart the whole sequence
//   pll_rst_o       : PLL RESET, active high
//   sys_rst_n_o     : core logic reset, active low
//   periph_rst_n_o  : peripheral reset, active low, released last
//   ready_o, fail_o : high only in RUN / FAIL
//   relock_cnt_o    : saturating count of lock losses after release
//   state_o         : current FSM state
module pll_lock_rst_seq
  import pll_lock_rst_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DefPllRstCycles,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DefLockTimeoutCycles,
  parameter int unsigned LOCK_STABLE_CYCLES  = DefLockStableCycles,  // must be >= 2
  parameter int unsigned RST_STAGGER_CYCLES  = DefRstStaggerCycles,
  parameter int unsigned MAX_RETRIES         = DefMaxRetries,
  parameter int unsigned SYNC_STAGES         = DefSyncStages,
  parameter int unsigned CNT_W               = DefCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock_i,
  input  logic             soft_rst_i,
  output logic             pll_rst_o,
  output logic             sys_rst_n_o,
  output logic             periph_rst_n_o,
  output logic             ready_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] relock_cnt_o,
  output logic [2:0]       state_o
);

  localparam int unsigned MaxCycles = max_u(max_u(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                            max_u(LOCK_STABLE_CYCLES, RST_STAGGER_CYCLES));
  localparam int unsigned TimerW    = $clog2(MaxCycles) + 1;
  localparam int unsigned RetryW    = $clog2(MAX_RETRIES + 2);

  logic lock_s;

  cdc_sync_bit #(
    .Stages(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (pll_lock_i),
    .q_o  (lock_s)
  );

  state_e             state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [RetryW-1:0]  retry_q, retry_d;
  logic [CNT_W-1:0]   relock_q, relock_d;
  logic               timer_clr;
  logic               pll_rst_q, sys_rst_n_q, periph_rst_n_q, ready_q, fail_q;

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    relock_d  = relock_q;
    timer_clr = 1'b0;

    if (soft_rst_i) begin
      state_d   = StPllRst;
      retry_d   = '0;
      timer_clr = 1'b1;  // restart the pulse even if already in PLL_RST
    end else begin
      unique case (state_q)
        StPllRst: begin
          if (timer_q == TimerW'(PLL_RST_CYCLES - 1)) state_d = StWaitLock;
        end
        StWaitLock: begin
          if (lock_s) begin
            state_d = StStable;
          end else if (timer_q == TimerW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            if (retry_q < RetryW'(MAX_RETRIES)) begin
              retry_d = retry_q + 1'b1;
              state_d = StPllRst;
            end else begin
              state_d = StFail;
            end
          end
        end
        StStable: begin
          // The high sample that caused entry is the first of the required run.
          if (!lock_s) begin
            state_d = StWaitLock;
          end else if (timer_q == TimerW'(LOCK_STABLE_CYCLES - 2)) begin
            state_d = StRelSys;
            retry_d = '0;
          end
        end
        StRelSys: begin
          if (!lock_s) begin
            state_d = StPllRst;
            if (relock_q != '1) relock_d = relock_q + 1'b1;
          end else if (timer_q == TimerW'(RST_STAGGER_CYCLES - 1)) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (!lock_s) begin
            state_d = StPllRst;
            if (relock_q != '1) relock_d = relock_q + 1'b1;
          end
        end
        StFail: begin
          state_d = StFail;
        end
        default: begin
          state_d = StPllRst;
        end
      endcase
    end

    if (state_d != state_q) timer_clr = 1'b1;
    timer_d = timer_clr ? '0 : timer_q + 1'b1;
  end

  // Outputs are decoded from the next state so they change on the same edge as state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StPllRst;
      timer_q        <= '0;
      retry_q        <= '0;
      relock_q       <= '0;
      pll_rst_q      <= 1'b1;
      sys_rst_n_q    <= 1'b0;
      periph_rst_n_q <= 1'b0;
      ready_q        <= 1'b0;
      fail_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      retry_q        <= retry_d;
      relock_q       <= relock_d;
      pll_rst_q      <= (state_d == StPllRst);
      sys_rst_n_q    <= (state_d == StRelSys) || (state_d == StRun);
      periph_rst_n_q <= (state_d == StRun);
      ready_q        <= (state_d == StRun);
      fail_q         <= (state_d == StFail);
    end
  end

  assign pll_rst_o      = pll_rst_q;
  assign sys_rst_n_o    = sys_rst_n_q;
  assign periph_rst_n_o = periph_rst_n_q;
  assign ready_o        = ready_q;
  assign fail_o         = fail_q;
  assign relock_cnt_o   = relock_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Bench for pll_lock_rst_seq. Stimulus schedules lock behaviour in absolute cycles and pushes
// the expected output changes (cycle, output vector) into a queue; a monitor pops one entry
// for every observed change of the DUT output vector.
module tb_pll_lock_rst_seq;

  localparam int unsigned NRst   = 4;
  localparam int unsigned TOut   = 50;
  localparam int unsigned NStab  = 8;
  localparam int unsigned NStag  = 4;
  localparam int unsigned NRetry = 2;
  localparam int unsigned CntW   = 2;
  localparam int unsigned NSync  = 2;
  localparam int          CntMax = (1 << CntW) - 1;

  typedef logic [CntW+7:0] ovec_t;
  typedef struct {
    int    c;
    ovec_t v;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pll_lock_i = 1'b0;
  logic            soft_rst_i = 1'b0;
  logic            pll_rst_o, sys_rst_n_o, periph_rst_n_o, ready_o, fail_o;
  logic [CntW-1:0] relock_cnt_o;
  logic [2:0]      state_o;
  ovec_t           ov;

  always #5 clk = ~clk;

  pll_lock_rst_seq #(
    .PLL_RST_CYCLES     (NRst),
    .LOCK_TIMEOUT_CYCLES(TOut),
    .LOCK_STABLE_CYCLES (NStab),
    .RST_STAGGER_CYCLES (NStag),
    .MAX_RETRIES        (NRetry),
    .SYNC_STAGES        (NSync),
    .CNT_W              (CntW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_lock_i    (pll_lock_i),
    .soft_rst_i    (soft_rst_i),
    .pll_rst_o     (pll_rst_o),
    .sys_rst_n_o   (sys_rst_n_o),
    .periph_rst_n_o(periph_rst_n_o),
    .ready_o       (ready_o),
    .fail_o        (fail_o),
    .relock_cnt_o  (relock_cnt_o),
    .state_o       (state_o)
  );

  assign ov = {pll_rst_o, sys_rst_n_o, periph_rst_n_o, ready_o, fail_o, relock_cnt_o, state_o};

  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  int  relock_m = 0;
  bit  mon_en = 1'b0;
  ev_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output vector implied by a state: PLL reset only in PLL_RST, core reset released in
  // REL_SYS and RUN, peripherals/ready only in RUN, fail only in FAIL.
  function automatic ovec_t mk(input int st, input int rc);
    return {st == 0, st == 3 || st == 4, st == 4, st == 4, st == 5, CntW'(rc), 3'(st)};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic chkv(input string name, input ovec_t act, input ovec_t req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  task automatic exp_ev(input int c, input int st);
    ev_t e;
    e.c = c;
    e.v = mk(st, relock_m);
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Lock rises after edge k0; events pushed up to state 'upto' (2, 3 or 4).
  task automatic lock_up(input int k0, input int upto);
    wait_cyc(k0);
    pll_lock_i = 1'b1;
    exp_ev(k0 + NSync + 1, 2);
    if (upto >= 3) exp_ev(k0 + NSync + NStab, 3);
    if (upto >= 4) exp_ev(k0 + NSync + NStab + NStag, 4);
  endtask

  // PLL_RST entered at cycle p with no lock ever: NRetry+1 pulses, then FAIL.
  task automatic fail_seq(input int p, output int f);
    for (int j = 0; j <= int'(NRetry); j++) begin
      exp_ev(p + NRst, 1);
      if (j < int'(NRetry)) exp_ev(p + NRst + TOut, 0);
      p = p + NRst + TOut;
    end
    f = p;
    exp_ev(f, 5);
  endtask

  task automatic drop_lock(input int d);
    wait_cyc(d);
    pll_lock_i = 1'b0;
    relock_m   = (relock_m < CntMax) ? relock_m + 1 : CntMax;
    exp_ev(d + NSync + 1, 0);
  endtask

  initial begin : monitor
    ovec_t last;
    bit    armed;
    ev_t   e;
    armed = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        armed = 1'b0;
      end else if (!armed) begin
        armed = 1'b1;
        last  = ov;
      end else if (ov !== last) begin
        last = ov;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event at cycle %0d: got %h, expected no change", cyc, ov);
        end else begin
          e = exp_q.pop_front();
          chk("event_cycle", cyc, e.c);
          chkv("event_value", ov, e.v);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog at cycle %0d: got no finish, expected finish by cycle 20000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int r, w, k0, d, f, s, mode;

    // Reset state
    wait_cyc(3);
    chkv("reset_outputs", ov, mk(0, 0));
    chk("reset_pll_rst", int'(pll_rst_o), 1);
    mon_en = 1'b1;
    wait_cyc(5);
    rst_n = 1'b1;
    r = 5;

    // First WAIT_LOCK times out once, lock then arrives 10 cycles after the second pulse
    w = r + NRst;
    exp_ev(w, 1);
    exp_ev(w + TOut, 0);
    w = w + TOut + NRst;
    exp_ev(w, 1);
    k0 = w + 10;
    lock_up(k0, 2);

    // Lock losses from REL_SYS or RUN; the first one always from RUN
    for (int i = 0; i < 5; i++) begin
      mode = (i == 0) ? 0 : int'($urandom_range(0, 1));
      if (mode == 0) begin
        exp_ev(k0 + NSync + NStab, 3);
        exp_ev(k0 + NSync + NStab + NStag, 4);
        d = k0 + NSync + NStab + NStag + int'($urandom_range(0, 6));
      end else begin
        exp_ev(k0 + NSync + NStab, 3);
        d = k0 + NSync + NStab - 2 + int'($urandom_range(0, 2));
      end
      if (i == 0) begin
        wait_cyc(k0 + NSync + NStab + NStag + 1);
        chk("run_relock_zero", int'(relock_cnt_o), 0);
      end
      drop_lock(d);
      wait_cyc(d + NSync + 1);
      chk("loss_sys_rst_n", int'(sys_rst_n_o), 0);
      chk("loss_periph_rst_n", int'(periph_rst_n_o), 0);
      chk("loss_relock_cnt", int'(relock_cnt_o), relock_m);
      w = d + NSync + 1 + NRst;
      exp_ev(w, 1);
      k0 = w + int'($urandom_range(1, 30));
      lock_up(k0, 2);
    end

    // One-cycle lock glitch while in STABLE restarts the stable count
    d = k0 + int'($urandom_range(1, 6));
    wait_cyc(d);
    pll_lock_i = 1'b0;
    exp_ev(d + NSync + 1, 1);
    wait_cyc(d + 1);
    pll_lock_i = 1'b1;
    exp_ev(d + NSync + 2, 2);
    exp_ev(d + 1 + NSync + NStab, 3);
    exp_ev(d + 1 + NSync + NStab + NStag, 4);
    wait_cyc(d + NSync + 1);
    chk("glitch_state_wait", int'(state_o), 1);
    chk("glitch_relock_kept", int'(relock_cnt_o), relock_m);

    // Lock lost in RUN and never returns -> retries exhausted -> FAIL
    d = d + 1 + NSync + NStab + NStag + 2;
    drop_lock(d);
    fail_seq(d + NSync + 1, f);
    wait_cyc(f + 10);
    chk("fail_flag", int'(fail_o), 1);
    chk("fail_state", int'(state_o), 5);
    chk("fail_pll_rst_low", int'(pll_rst_o), 0);

    // soft_rst_i leaves FAIL, keeps relock count, clears retries (full 3 pulses again)
    s = cyc;
    exp_ev(s + 1, 0);
    soft_rst_i = 1'b1;
    wait_cyc(s + 1);
    soft_rst_i = 1'b0;
    chk("soft_state", int'(state_o), 0);
    chk("soft_fail_clear", int'(fail_o), 0);
    chk("soft_relock_kept", int'(relock_cnt_o), relock_m);
    fail_seq(s + 1, f);
    wait_cyc(f + 5);
    s = cyc;
    exp_ev(s + 1, 0);
    soft_rst_i = 1'b1;
    wait_cyc(s + 1);
    soft_rst_i = 1'b0;
    w = s + 1 + NRst;
    exp_ev(w, 1);
    k0 = w + int'($urandom_range(1, 40));
    lock_up(k0, 3);

    // Async reset in the middle of REL_SYS
    wait_cyc(k0 + NSync + NStab + 1);
    relock_m = 0;
    exp_ev(cyc, 0);
    rst_n      = 1'b0;
    pll_lock_i = 1'b0;
    #1;
    chkv("async_reset_outputs", ov, mk(0, 0));
    wait_cyc(cyc + 2);
    rst_n = 1'b1;
    w = cyc + NRst;
    exp_ev(w, 1);
    k0 = w + int'($urandom_range(1, 40));
    lock_up(k0, 4);
    wait_cyc(k0 + NSync + NStab + NStag + 3);
    chk("final_ready", int'(ready_o), 1);
    chk("final_relock", int'(relock_cnt_o), 0);
    wait_cyc(cyc + 10);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
